// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the decode stage: opcodes, immediate formats,
// ALU operations and writeback result sources.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

endpackage

// File: rtl/regfile.sv
// 32-entry register file: async-reset storage, one write port, two
// combinational read ports. Write-through on a same-cycle hit when DECODE_BYPASS_EN is defined.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_waddr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef DECODE_BYPASS_EN
    logic w_hit1;
    logic w_hit2;

    assign w_hit1   = w_wr_en && (i_waddr == i_raddr1);
    assign w_hit2   = w_wr_en && (i_waddr == i_raddr2);
    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : (w_hit1 ? i_wdata : r_mem[i_raddr1]);
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : (w_hit2 ? i_wdata : r_mem[i_raddr2]);
`else
    // Without bypass the read sees the pre-write value; hazard unit covers it.
    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_mem[i_raddr2];
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, register read, immediate generation,
// main/ALU decode and the flushable ID/EX register. Optional macro: DECODE_BYPASS_EN.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic            IllegalE
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_imm;
    logic            w_reg_write, w_mem_write, w_jump, w_branch, w_alu_src;
    logic            w_illegal, w_alu_by_funct;
    result_src_t     w_result_src;
    imm_src_t        w_imm_src;
    alu_ctrl_t       w_alu_ctrl;

    assign w_opcode = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (RegWriteW),
        .i_waddr  (RdW),
        .i_wdata  (ResultW),
        .i_raddr1 (Rs1D),
        .i_raddr2 (Rs2D),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    always_comb begin
        w_reg_write    = 1'b0;
        w_mem_write    = 1'b0;
        w_jump         = 1'b0;
        w_branch       = 1'b0;
        w_alu_src      = 1'b0;
        w_result_src   = RES_ALU;
        w_imm_src      = IMM_I;
        w_alu_ctrl     = ALU_ADD;
        w_illegal      = 1'b0;
        w_alu_by_funct = 1'b0;
        case (w_opcode)
            OP_LW:  begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_result_src = RES_MEM; end
            OP_SW:  begin w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm_src = IMM_S; end
            OP_R:   begin w_reg_write = 1'b1; w_alu_by_funct = 1'b1; end
            OP_I:   begin w_reg_write = 1'b1; w_alu_src = 1'b1; w_alu_by_funct = 1'b1; end
            OP_BEQ: begin w_branch = 1'b1; w_imm_src = IMM_B; w_alu_ctrl = ALU_SUB; end
            OP_JAL: begin w_reg_write = 1'b1; w_jump = 1'b1; w_result_src = RES_PC4; w_imm_src = IMM_J; end
            default: w_illegal = 1'b1;
        endcase
        // funct7[5] selects sub only for R-type; addi has no subtract form.
        if (w_alu_by_funct) begin
            case (w_funct3)
                3'b000:  w_alu_ctrl = (w_opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  w_alu_ctrl = ALU_SLT;
                3'b110:  w_alu_ctrl = ALU_OR;
                3'b111:  w_alu_ctrl = ALU_AND;
                default: w_illegal  = 1'b1;
            endcase
        end
        if (w_illegal) begin
            w_reg_write  = 1'b0;
            w_mem_write  = 1'b0;
            w_jump       = 1'b0;
            w_branch     = 1'b0;
            w_alu_src    = 1'b0;
            w_result_src = RES_ALU;
            w_alu_ctrl   = ALU_ADD;
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_imm_src)
            IMM_I: w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S: w_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: w_imm = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J: w_imm = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    logic [XLEN-1:0] r_rd1, r_rd2, r_imm, r_pc, r_pc4;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic            r_reg_write, r_mem_write, r_jump, r_branch, r_alu_src, r_illegal;
    logic [1:0]      r_result_src;
    logic [2:0]      r_alu_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || FlushE) begin
            r_rd1 <= '0; r_rd2 <= '0; r_imm <= '0; r_pc <= '0; r_pc4 <= '0;
            r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0;
            r_reg_write <= 1'b0; r_mem_write <= 1'b0; r_jump <= 1'b0;
            r_branch <= 1'b0; r_alu_src <= 1'b0; r_illegal <= 1'b0;
            r_result_src <= '0; r_alu_ctrl <= '0;
        end else begin
            r_rd1 <= w_rd1; r_rd2 <= w_rd2; r_imm <= w_imm; r_pc <= PCD; r_pc4 <= PCPlus4D;
            r_rs1 <= Rs1D; r_rs2 <= Rs2D; r_rd <= InstrD[11:7];
            r_reg_write <= w_reg_write; r_mem_write <= w_mem_write; r_jump <= w_jump;
            r_branch <= w_branch; r_alu_src <= w_alu_src; r_illegal <= w_illegal;
            r_result_src <= w_result_src; r_alu_ctrl <= w_alu_ctrl;
        end
    end

    assign RD1E        = r_rd1;
    assign RD2E        = r_rd2;
    assign ImmExtE     = r_imm;
    assign PCE         = r_pc;
    assign PCPlus4E    = r_pc4;
    assign Rs1E        = r_rs1;
    assign Rs2E        = r_rs2;
    assign RdE         = r_rd;
    assign RegWriteE   = r_reg_write;
    assign MemWriteE   = r_mem_write;
    assign JumpE       = r_jump;
    assign BranchE     = r_branch;
    assign ALUSrcE     = r_alu_src;
    assign ResultSrcE  = r_result_src;
    assign ALUControlE = r_alu_ctrl;
    assign IllegalE    = r_illegal;

endmodule
